// File: rtl/alu_exec_ctrl.sv
// Issue/writeback controller around a combinational ALU: reads operands from a small register
// file, drives the ALU for one cycle, then retires the result through a valid/ready handshake.
module alu_exec_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [15:0]       instr_i,
  output logic [2:0]        alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_zero_o,
  output logic              zero_flag_o,
  output logic              busy_o,
  input  logic [REG_AW-1:0] dbg_sel_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  localparam int unsigned NumRegs = 2 ** REG_AW;

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rf_q [NumRegs];
  logic [DATA_W-1:0] rf_d [NumRegs];
  logic [2:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_zero_q, wb_zero_d;
  logic              zero_flag_q, zero_flag_d;

  logic [2:0]        op_f;
  logic [REG_AW-1:0] rd_f, ra_f, rb_f;
  logic              use_imm_f;
  logic [7:0]        imm_f;
  logic [DATA_W-1:0] ra_data, rb_data;

  assign op_f      = instr_i[15:13];
  assign rd_f      = instr_i[11 +: REG_AW];
  assign ra_f      = instr_i[9 +: REG_AW];
  assign use_imm_f = instr_i[8];
  assign imm_f     = instr_i[7:0];
  assign rb_f      = imm_f[REG_AW-1:0];

  // R0 is hardwired to zero on every read path.
  assign ra_data    = (ra_f == '0) ? '0 : rf_q[ra_f];
  assign rb_data    = (rb_f == '0) ? '0 : rf_q[rb_f];
  assign dbg_data_o = (dbg_sel_i == '0) ? '0 : rf_q[dbg_sel_i];

  always_comb begin
    state_d       = state_q;
    rf_d          = rf_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    rd_d          = rd_q;
    wb_data_d     = wb_data_q;
    wb_zero_d     = wb_zero_q;
    zero_flag_d   = zero_flag_q;
    instr_ready_o = 1'b0;
    wb_valid_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          alu_op_d = op_f;
          alu_a_d  = ra_data;
          alu_b_d  = use_imm_f ? DATA_W'(imm_f) : rb_data;
          rd_d     = rd_f;
          state_d  = StExec;
        end
      end
      StExec: begin
        wb_data_d = alu_result_i;
        wb_zero_d = alu_zero_i;
        state_d   = StWb;
      end
      StWb: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i) begin
          if (rd_q != '0) rf_d[rd_q] = wb_data_q;
          zero_flag_d = wb_zero_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      for (int unsigned i = 0; i < NumRegs; i++) rf_q[i] <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rd_q        <= '0;
      wb_data_q   <= '0;
      wb_zero_q   <= 1'b0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rf_q        <= rf_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rd_q        <= rd_d;
      wb_data_q   <= wb_data_d;
      wb_zero_q   <= wb_zero_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  assign alu_op_o    = alu_op_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign wb_rd_o     = rd_q;
  assign wb_data_o   = wb_data_q;
  assign wb_zero_o   = wb_zero_q;
  assign zero_flag_o = zero_flag_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl; a small combinational ALU model sits on the ALU ports.
module tb_alu_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [15:0] instr;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_res;
  logic       alu_z;
  logic       wb_valid, wb_ready;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic       wb_zero, zflag, busy;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DATA_W(8), .REG_AW(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid_i(instr_valid),
    .instr_ready_o(instr_ready),
    .instr_i      (instr),
    .alu_op_o     (alu_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_result_i (alu_res),
    .alu_zero_i   (alu_z),
    .wb_valid_o   (wb_valid),
    .wb_ready_i   (wb_ready),
    .wb_rd_o      (wb_rd),
    .wb_data_o    (wb_data),
    .wb_zero_o    (wb_zero),
    .zero_flag_o  (zflag),
    .busy_o       (busy),
    .dbg_sel_i    (dbg_sel),
    .dbg_data_o   (dbg_data)
  );

  always_comb begin
    alu_res = '0;
    case (alu_op)
      3'b000: alu_res = alu_a + alu_b;
      3'b001: alu_res = alu_a - alu_b;
      3'b010: alu_res = alu_a & alu_b;
      3'b011: alu_res = alu_a | alu_b;
      3'b100: alu_res = alu_a ^ alu_b;
      3'b101: alu_res = ~alu_a;
      3'b110: alu_res = alu_a << 1;
      default: alu_res = alu_a >> 1;
    endcase
    alu_z = (alu_res == 8'd0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic rd_dbg(input logic [1:0] sel, output logic [7:0] val);
    dbg_sel = sel;
    #1;
    val = dbg_data;
  endtask

  // Issues one instruction from IDLE with wb_ready high; returns just after the retire edge.
  task automatic run_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                           input logic ui, input logic [7:0] imm,
                           output logic [7:0] data, output logic z, output int lat);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = {op, rd, ra, ui, imm};
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 1;
    while (!wb_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    data = wb_data;
    z    = wb_zero;
    @(posedge clk);
  endtask

  logic [7:0] d, v;
  logic       z, stable;
  int         lat, k, retires, accepts;
  bit         done;

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; wb_ready = 1'b1; dbg_sel = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", instr_ready, 1);
    check_eq("rst_wb_valid", wb_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_zflag", zflag, 0);
    check_eq("rst_alu", {alu_op, alu_a, alu_b}, 0);
    check_eq("rst_wb", {wb_rd, wb_data, wb_zero}, 0);

    // Register/immediate operands
    run_instr(OpAdd, 2'd1, 2'd0, 1'b1, 8'd10, d, z, lat);
    check_eq("t1_r1_data", d, 10);
    check_eq("t1_latency", lat, 2);
    run_instr(OpAdd, 2'd2, 2'd0, 1'b1, 8'd20, d, z, lat);
    check_eq("t1_r2_data", d, 20);
    run_instr(OpAdd, 2'd3, 2'd1, 1'b0, 8'd2, d, z, lat);
    check_eq("t1_r3_data", d, 30);
    check_eq("t1_r3_zero", z, 0);
    check_eq("t1_alu_ab", {alu_a, alu_b}, {8'd10, 8'd20});
    @(negedge clk);
    rd_dbg(2'd3, v);
    check_eq("t1_dbg_r3", v, 30);

    // Wrap-around to zero
    run_instr(OpAdd, 2'd1, 2'd0, 1'b1, 8'd255, d, z, lat);
    check_eq("t2_r1_255", d, 255);
    run_instr(OpAdd, 2'd1, 2'd1, 1'b1, 8'd1, d, z, lat);
    check_eq("t2_wrap_data", d, 0);
    check_eq("t2_wrap_zero", z, 1);
    @(negedge clk);
    check_eq("t2_zflag", zflag, 1);

    // Write to R0 retires but leaves R0 at zero
    run_instr(OpAdd, 2'd0, 2'd0, 1'b1, 8'd5, d, z, lat);
    check_eq("t4_r0_data", d, 5);
    @(negedge clk);
    rd_dbg(2'd0, v);
    check_eq("t4_dbg_r0", v, 0);
    check_eq("t4_zflag", zflag, 0);

    // Back-pressure: hold WB for 5 cycles, offer an instruction that must be ignored
    @(negedge clk);
    wb_ready    = 1'b0;
    instr_valid = 1'b1;
    instr       = {OpAdd, 2'd2, 2'd2, 1'b1, 8'd3};
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 1;
    while (!wb_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_eq("t3_latency", lat, 2);
    check_eq("t3_data", wb_data, 23);
    instr_valid = 1'b1;
    instr       = {OpAdd, 2'd3, 2'd0, 1'b1, 8'd99};
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      rd_dbg(2'd2, v);
      if (!(wb_valid && wb_data == 8'd23 && wb_rd == 2'd2 && !wb_zero && !instr_ready &&
            v == 8'd20)) stable = 1'b0;
    end
    check_eq("t3_hold_stable", stable, 1);
    rd_dbg(2'd2, v);
    check_eq("t3_r2_before_hs", v, 20);
    instr_valid = 1'b0;
    wb_ready    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("t3_wb_valid_drop", wb_valid, 0);
    check_eq("t3_ready_back", instr_ready, 1);
    rd_dbg(2'd2, v);
    check_eq("t3_r2_after_hs", v, 23);
    rd_dbg(2'd3, v);
    check_eq("t3_r3_untouched", v, 30);

    // Throughput: 10 back-to-back increments of R1 (R1=0)
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = {OpAdd, 2'd1, 2'd1, 1'b1, 8'd1};
    k = 0; retires = 0; accepts = 0; done = 1'b0;
    while (!done && k < 100) begin
      if (instr_valid && instr_ready) accepts++;
      if (wb_valid && wb_ready) begin
        retires++;
        if (retires == 10) begin
          done = 1'b1;
          instr_valid = 1'b0;
        end
      end
      if (!done) begin
        @(posedge clk);
        @(negedge clk);
        k++;
      end
    end
    check_eq("t5_cycles", k + 1, 30);
    check_eq("t5_accepts", accepts, 10);
    @(posedge clk);
    @(negedge clk);
    rd_dbg(2'd1, v);
    check_eq("t5_r1", v, 10);

    // Reset during EXEC
    run_instr(OpAdd, 2'd1, 2'd0, 1'b1, 8'd7, d, z, lat);
    run_instr(OpAdd, 2'd2, 2'd0, 1'b1, 8'd0, d, z, lat);
    @(negedge clk);
    check_eq("t6_zflag_set", zflag, 1);
    instr_valid = 1'b1;
    instr       = {OpSub, 2'd1, 2'd1, 1'b1, 8'd1};
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check_eq("t6_exec_busy", busy, 1);
    check_eq("t6_exec_ops", {alu_op, alu_a, alu_b}, {OpSub, 8'd7, 8'd1});
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_wb_valid", wb_valid, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_zflag", zflag, 0);
    check_eq("t6_rst_alu", {alu_op, alu_a, alu_b}, 0);
    rd_dbg(2'd1, v);
    check_eq("t6_rst_r1", v, 0);
    rd_dbg(2'd3, v);
    check_eq("t6_rst_r3", v, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_post_wb_valid", wb_valid, 0);
    check_eq("t6_post_ready", instr_ready, 1);
    rd_dbg(2'd1, v);
    check_eq("t6_post_r1", v, 0);

    // Operation after reset
    run_instr(OpAdd, 2'd3, 2'd0, 1'b1, 8'd4, d, z, lat);
    check_eq("post_rst_data", d, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
